// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the generic FIR, its coefficient ROM and the
//   coefficient bank loader.
//   - FIR_NTAPS / FIR_TAP_W / FIR_NBANKS : default geometry shared by all
//     FIR-related blocks.
//   - loader_state_t : bank loader FSM states.
//   - addr_op_t      : command from the loader FSM to the tap address
//     generator.
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_NTAPS  = 16;
    localparam int FIR_TAP_W  = 16;
    localparam int FIR_NBANKS = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } loader_state_t;

    // HOLD  : keep address and index
    // BASE  : present the bank base address
    // FIRST : present base+1 and restart the tap index at 0
    // STEP  : run the address two taps ahead of the index, then advance
    typedef enum logic [1:0] {
        ADDR_HOLD  = 2'd0,
        ADDR_BASE  = 2'd1,
        ADDR_FIRST = 2'd2,
        ADDR_STEP  = 2'd3
    } addr_op_t;

endpackage

// File: rtl/fir_tap_addr_gen.sv
// ---------------------------------------------------------------------------
// fir_tap_addr_gen
//   Coefficient ROM address generator for the bank loader. Holds the base
//   address of the selected bank, the index of the tap currently being
//   written, and the registered ROM address.
//
//   Ports
//     i_clk      in   1       clock, posedge
//     i_reset    in   1       synchronous active-low reset
//     i_latch    in   1       capture base = i_bank*NTAPS
//     i_bank     in   BANK_W  bank to latch
//     i_op       in   op      address command (see addr_op_t)
//     o_rom_addr out  ADDR_W  registered ROM address
//     o_idx      out  IDX_W   index of the tap being written
//     o_last     out  1       o_idx == NTAPS-1
//
//   The ROM address is registered and the ROM adds one more cycle, so the
//   address runs two taps ahead of the data being written: while tap idx is
//   written the next address computed is base+idx+2, clamped at the last tap
//   of the bank so the address never leaves the selected bank.
// ---------------------------------------------------------------------------
module fir_tap_addr_gen
    import fir_pkg::*;
#(
    parameter int NTAPS  = FIR_NTAPS,
    parameter int NBANKS = FIR_NBANKS,
    parameter int BANK_W = 2,
    parameter int ADDR_W = 6,
    parameter int IDX_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_latch,
    input  logic [BANK_W-1:0] i_bank,
    input  addr_op_t          i_op,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_last
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              last;

    assign last = (idx_q == IDX_W'(NTAPS - 1));

    always_comb begin
        base_d = base_q;
        addr_d = addr_q;
        idx_d  = idx_q;
        if (i_latch) begin
            base_d = ADDR_W'(int'(i_bank) * NTAPS);
        end
        case (i_op)
            ADDR_BASE: begin
                addr_d = base_q;
            end
            ADDR_FIRST: begin
                addr_d = base_q + ADDR_W'(1);
                idx_d  = '0;
            end
            ADDR_STEP: begin
                // Once base+idx+2 would pass the last tap, park on the last tap.
                if (idx_q >= IDX_W'(NTAPS - 2)) begin
                    addr_d = base_q + ADDR_W'(NTAPS - 1);
                end else begin
                    addr_d = base_q + ADDR_W'(idx_q) + ADDR_W'(2);
                end
                if (!last) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            base_q <= '0;
            addr_q <= '0;
            idx_q  <= '0;
        end else begin
            base_q <= base_d;
            addr_q <= addr_d;
            idx_q  <= idx_d;
        end
    end

    assign o_rom_addr = addr_q;
    assign o_idx      = idx_q;
    assign o_last     = last;

endmodule

// File: rtl/fir_bank_loader.sv
// ---------------------------------------------------------------------------
// fir_bank_loader
//   Loads one coefficient bank from a synchronous ROM (1-cycle read latency)
//   into the FIR tap-write port. A load clears the FIR, then writes NTAPS
//   taps in index order. The FIR sample strobe is gated off until a full
//   bank is resident and while a load is running.
//
//   Ports
//     i_clk       in   1       clock, posedge
//     i_reset     in   1       synchronous active-low reset
//     i_start     in   1       load request, rising edge triggers
//     i_bank      in   BANK_W  bank to load, sampled with the triggering edge
//     i_ce        in   1       upstream sample strobe
//     o_rom_addr  out  ADDR_W  coefficient ROM address
//     i_rom_data  in   TAP_W   ROM read data
//     o_tap_wr    out  1       FIR tap write strobe
//     o_tap       out  TAP_W   FIR tap value (i_rom_data passed through)
//     o_fir_clr   out  1       one-cycle FIR clear
//     o_fir_ce    out  1       gated sample strobe to the FIR
//     o_busy      out  1       load in progress
//     o_done      out  1       one-cycle pulse, load complete
//     o_err       out  1       one-cycle pulse, start with an invalid bank
//     o_bank      out  BANK_W  bank loaded / being loaded
//     o_loaded    out  1       a complete bank is resident in the FIR
//     o_state     out  state   FSM state (debug)
//     o_tap_idx   out  IDX_W   tap index being written (debug)
//
//   Handshake: a 0->1 transition of i_start seen while IDLE starts a load;
//   o_busy is high from the clear cycle through the last tap write, then
//   o_done pulses for one cycle and the loader is IDLE again. Edges seen
//   while not IDLE are dropped, never queued.
// ---------------------------------------------------------------------------
module fir_bank_loader
    import fir_pkg::*;
#(
    parameter  int NTAPS  = FIR_NTAPS,
    parameter  int TAP_W  = FIR_TAP_W,
    parameter  int NBANKS = FIR_NBANKS,
    localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1,
    localparam int ADDR_W = $clog2(NBANKS * NTAPS),
    localparam int IDX_W  = $clog2(NTAPS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [BANK_W-1:0] i_bank,
    input  logic              i_ce,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [TAP_W-1:0]  i_rom_data,
    output logic              o_tap_wr,
    output logic [TAP_W-1:0]  o_tap,
    output logic              o_fir_clr,
    output logic              o_fir_ce,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [BANK_W-1:0] o_bank,
    output logic              o_loaded,
    output loader_state_t     o_state,
    output logic [IDX_W-1:0]  o_tap_idx
);

    // One extra bit so NBANKS itself is representable for the range check.
    localparam logic [BANK_W:0] NBANKS_L = (BANK_W + 1)'(NBANKS);

    loader_state_t     state_q, state_d;
    logic              start_q;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              loaded_q, loaded_d;
    logic              err_q, err_d;

    logic              start_edge;
    logic              bank_ok;
    logic              accept;
    logic              reject;
    addr_op_t          addr_op;
    logic              last;

    assign start_edge = i_start & ~start_q;
    assign bank_ok    = ({1'b0, i_bank} < NBANKS_L);
    assign accept     = (state_q == IDLE) & start_edge & bank_ok;
    assign reject     = (state_q == IDLE) & start_edge & ~bank_ok;

    // FSM next state and Moore outputs
    always_comb begin
        state_d   = state_q;
        addr_op   = ADDR_HOLD;
        o_busy    = 1'b0;
        o_fir_clr = 1'b0;
        o_tap_wr  = 1'b0;
        o_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                o_fir_clr = 1'b1;
                o_busy    = 1'b1;
                addr_op   = ADDR_BASE;
                state_d   = FETCH;
            end
            FETCH: begin
                o_busy  = 1'b1;
                addr_op = ADDR_FIRST;
                state_d = LOAD;
            end
            LOAD: begin
                o_busy   = 1'b1;
                o_tap_wr = 1'b1;
                addr_op  = ADDR_STEP;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bank, resident flag and error pulse
    always_comb begin
        bank_d   = bank_q;
        loaded_d = loaded_q;
        err_d    = reject;
        if (accept) begin
            bank_d   = i_bank;
            loaded_d = 1'b0;
        end else if (state_q == DONE) begin
            loaded_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            // Starts high so a request held through reset is not an edge.
            start_q  <= 1'b1;
            bank_q   <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= i_start;
            bank_q   <= bank_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
        end
    end

    fir_tap_addr_gen #(
        .NTAPS  (NTAPS),
        .NBANKS (NBANKS),
        .BANK_W (BANK_W),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_latch    (accept),
        .i_bank     (i_bank),
        .i_op       (addr_op),
        .o_rom_addr (o_rom_addr),
        .o_idx      (o_tap_idx),
        .o_last     (last)
    );

    // Samples arriving during a load are dropped, not buffered.
    assign o_fir_ce = i_ce & loaded_q & (state_q == IDLE);
    assign o_tap    = i_rom_data;
    assign o_err    = err_q;
    assign o_bank   = bank_q;
    assign o_loaded = loaded_q;
    assign o_state  = state_q;

endmodule
